// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared states, glyphs and helpers for the FND scan controller
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}; dp is off in all of them
  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  localparam logic [3:0] DIGIT_OFF = 4'b1111;

  // Active-low one-hot anode enable for a digit index
  function automatic logic [3:0] digit_onehot_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/fnd_seg_encoder.sv
// rtl/fnd_seg_encoder.sv - BCD digit plus dp to active-low 7-segment pattern
module fnd_seg_encoder (
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);
  import fnd_pkg::*;

  logic [7:0] glyph;

  // Glyph lookup; non-decimal codes show a dash, a blanked digit keeps only dp
  always_comb begin
    glyph = SEG_DASH;
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
    if (blank) begin
      glyph = SEG_OFF;
    end
    seg = {~dp, glyph[6:0]};
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - 4-digit FND scan with blanking and frame-synchronous updates (option: FND_LEADING_ZERO_BLANK_EN)
module fnd_scan_controller #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_update,
  input  logic [15:0] i_bcd,
  input  logic [3:0]  i_dp,
  output logic [3:0]  o_digit,
  output logic [7:0]  o_seg,
  output logic [1:0]  o_digit_sel,
  output logic        o_pending,
  output logic        o_frame_done
);
  import fnd_pkg::*;

  localparam int              CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   slot_cnt, slot_cnt_nxt;
  logic [1:0]         digit_idx, digit_idx_nxt;
  logic               frame_end;

  logic [15:0]        pend_bcd, disp_bcd;
  logic [3:0]         pend_dp, disp_dp;
  logic               pend_flag;

  logic [3:0]         cur_bcd;
  logic               cur_dp;
  logic               cur_blank;
  logic [7:0]         enc_seg;

  // Scan state, slot counter and digit index
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      state     <= state_nxt;
      slot_cnt  <= slot_cnt_nxt;
      digit_idx <= digit_idx_nxt;
    end
  end

  // Next-state: blank window then show window per slot; disable wins over everything
  always_comb begin
    state_nxt     = state;
    slot_cnt_nxt  = slot_cnt;
    digit_idx_nxt = digit_idx;
    frame_end     = 1'b0;
    if (!i_en) begin
      state_nxt     = IDLE;
      slot_cnt_nxt  = '0;
      digit_idx_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt     = BLANK;
          slot_cnt_nxt  = '0;
          digit_idx_nxt = '0;
        end
        BLANK: begin
          slot_cnt_nxt = slot_cnt + 1'b1;
          if (slot_cnt == BLANK_LAST) begin
            state_nxt = SHOW;
          end
        end
        SHOW: begin
          if (slot_cnt == SLOT_LAST) begin
            state_nxt     = BLANK;
            slot_cnt_nxt  = '0;
            digit_idx_nxt = digit_idx + 2'd1;
            frame_end     = (digit_idx == 2'd3);
          end else begin
            slot_cnt_nxt = slot_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt     = IDLE;
          slot_cnt_nxt  = '0;
          digit_idx_nxt = '0;
        end
      endcase
    end
  end

  // Double buffer: strobes land in pending, committed only at the frame boundary
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend_bcd  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      disp_bcd  <= '0;
      disp_dp   <= '0;
    end else if (i_update && (state == IDLE || frame_end)) begin
      disp_bcd  <= i_bcd;
      disp_dp   <= i_dp;
      pend_flag <= 1'b0;
    end else begin
      if (frame_end && pend_flag) begin
        disp_bcd  <= pend_bcd;
        disp_dp   <= pend_dp;
        pend_flag <= 1'b0;
      end
      if (i_update) begin
        pend_bcd  <= i_bcd;
        pend_dp   <= i_dp;
        pend_flag <= 1'b1;
      end
    end
  end

  assign cur_bcd = disp_bcd[{digit_idx, 2'b00} +: 4];
  assign cur_dp  = disp_dp[digit_idx];

`ifdef FND_LEADING_ZERO_BLANK_EN
  // Leading zeros above the selected digit suppress it; digit 0 always shows
  always_comb begin
    cur_blank = 1'b0;
    case (digit_idx)
      2'd3:    cur_blank = (disp_bcd[15:12] == 4'd0);
      2'd2:    cur_blank = (disp_bcd[15:8] == 8'd0);
      2'd1:    cur_blank = (disp_bcd[15:4] == 12'd0);
      default: cur_blank = 1'b0;
    endcase
  end
`else
  assign cur_blank = 1'b0;
`endif

  fnd_seg_encoder u_seg_encoder (
    .bcd   (cur_bcd),
    .dp    (cur_dp),
    .blank (cur_blank),
    .seg   (enc_seg)
  );

  // Registered outputs, one cycle behind the scan state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_digit      <= DIGIT_OFF;
      o_seg        <= SEG_OFF;
      o_digit_sel  <= '0;
      o_pending    <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_digit_sel  <= digit_idx;
      o_pending    <= pend_flag;
      o_frame_done <= frame_end;
      if (state == SHOW) begin
        o_digit <= (cur_blank && !cur_dp) ? DIGIT_OFF : digit_onehot_n(digit_idx);
        o_seg   <= enc_seg;
      end else begin
        o_digit <= DIGIT_OFF;
        o_seg   <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - scoreboard bench for fnd_scan_controller (honours FND_LEADING_ZERO_BLANK_EN)
module tb_fnd_scan_controller;

  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        upd;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic [3:0]  o_digit;
  logic [7:0]  o_seg;
  logic [1:0]  o_digit_sel;
  logic        o_pending;
  logic        o_frame_done;

  always #5 clk = ~clk;

  fnd_scan_controller #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_en         (en),
    .i_update     (upd),
    .i_bcd        (bcd),
    .i_dp         (dp),
    .o_digit      (o_digit),
    .o_seg        (o_seg),
    .o_digit_sel  (o_digit_sel),
    .o_pending    (o_pending),
    .o_frame_done (o_frame_done)
  );

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  task automatic push_slot(input int i, input logic [3:0] v, input logic d);
    exp_t e;
    logic [7:0] g;
    g = glyph(v);
    e.dig = ~(4'b0001 << i);
    e.seg = {~d, g[6:0]};
    sb.push_back(e);
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
    for (int i = 0; i < 4; i++) push_slot(i, v[i*4 +: 4], d[i]);
  endtask

  // Scoreboard monitor: each SHOW run pops one expected slot
  logic [3:0] prev_digit = 4'hF;
  bit         mon_on = 1'b0;
  bit         in_run = 1'b0;
  bit         run_ok;
  int         run_len;
  exp_t       cur;

  always @(negedge clk) begin
    if (mon_on) begin
      if (o_digit !== 4'hF) begin
        if (prev_digit === 4'hF) begin
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            in_run = 1'b1;
            run_len = 1;
            run_ok = 1'b1;
            checks++;
            if (o_digit !== cur.dig) begin
              errors++;
              $display("FAIL slot_digit got %b want %b", o_digit, cur.dig);
            end
            checks++;
            if (o_seg !== cur.seg) begin
              errors++;
              $display("FAIL slot_seg digit %b got %h want %h", cur.dig, o_seg, cur.seg);
            end
          end
        end else if (in_run) begin
          run_len++;
          if (o_digit !== cur.dig || o_seg !== cur.seg) run_ok = 1'b0;
        end
      end else if (in_run) begin
        in_run = 1'b0;
        checks++;
        if (run_len != SD - BC) begin
          errors++;
          $display("FAIL slot_len digit %b got %0d want %0d", cur.dig, run_len, SD - BC);
        end
        checks++;
        if (!run_ok) begin
          errors++;
          $display("FAIL slot_stable digit %b got unstable want stable", cur.dig);
        end
      end
    end
    prev_digit = o_digit;
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; upd = 1'b0; bcd = '0; dp = '0;
    repeat (3) @(negedge clk);
    checks++; if (o_digit !== 4'hF) begin errors++; $display("FAIL rst_digit got %b want 1111", o_digit); end
    checks++; if (o_seg !== 8'hFF) begin errors++; $display("FAIL rst_seg got %h want ff", o_seg); end
    checks++; if (o_digit_sel !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", o_digit_sel); end
    checks++; if (o_pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b want 0", o_pending); end
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b want 0", o_frame_done); end
    rst = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;
  endtask

  task automatic test_scan_basic();
    int n;
    upd = 1'b1; bcd = 16'h1234; dp = 4'h0;
    @(negedge clk);
    upd = 1'b0;
    @(negedge clk);
    checks++; if (o_pending !== 1'b0) begin errors++; $display("FAIL idle_update_pending got %b want 0", o_pending); end
    push_frame(16'h1234, 4'h0);
    en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (o_digit === 4'hF && n < 20);
    checks++; if (n != 4) begin errors++; $display("FAIL first_latency got %0d want 4", n); end
    n = 0;
    while (o_digit === 4'b1110 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (o_digit === 4'hF && n < 20) begin @(negedge clk); n++; end
    checks++; if (n != BC) begin errors++; $display("FAIL blank_gap got %0d want %0d", n, BC); end
    n = 0;
    while ((sb.size() != 0 || in_run) && n < 120) begin @(negedge clk); n++; end
    checks++; if (sb.size() != 0 || in_run) begin errors++; $display("FAIL basic_drain got %0d want 0", sb.size()); end
    n = 0;
    do begin @(negedge clk); n++; end while (!o_frame_done && n < 40);
    @(negedge clk);
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width got %b want 0", o_frame_done); end
    n = 1;
    while (!o_frame_done && n < 40) begin @(negedge clk); n++; end
    checks++; if (n != 4 * SD || !o_frame_done) begin errors++; $display("FAIL frame_period got %0d want %0d", n, 4 * SD); end
  endtask

  task automatic test_pending();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (o_digit !== 4'b1101 && n < 40);
    upd = 1'b1; bcd = 16'h5678; dp = 4'h0;
    @(negedge clk);
    upd = 1'b0;
    @(negedge clk);
    checks++; if (o_pending !== 1'b1) begin errors++; $display("FAIL pend_set got %b want 1", o_pending); end
    n = 0;
    while (o_digit !== 4'b1011 && n < 40) begin @(negedge clk); n++; end
    checks++; if (o_seg !== glyph(4'd2)) begin errors++; $display("FAIL old_value_kept got %h want %h", o_seg, glyph(4'd2)); end
    n = 0;
    while (!o_frame_done && n < 40) begin @(negedge clk); n++; end
    checks++; if (o_pending !== 1'b1) begin errors++; $display("FAIL pend_at_boundary got %b want 1", o_pending); end
    push_frame(16'h5678, 4'h0);
    @(negedge clk);
    checks++; if (o_pending !== 1'b0) begin errors++; $display("FAIL pend_clear got %b want 0", o_pending); end
    n = 0;
    while ((sb.size() != 0 || in_run) && n < 120) begin @(negedge clk); n++; end
    checks++; if (sb.size() != 0 || in_run) begin errors++; $display("FAIL pend_drain got %0d want 0", sb.size()); end
  endtask

  task automatic test_last_write();
    int n;
    n = 0;
    while (o_digit !== 4'b1110 && n < 60) begin @(negedge clk); n++; end
    upd = 1'b1; bcd = 16'h1111;
    @(negedge clk);
    upd = 1'b0;
    n = 0;
    while (o_digit !== 4'b1011 && n < 40) begin @(negedge clk); n++; end
    upd = 1'b1; bcd = 16'h2222;
    @(negedge clk);
    upd = 1'b0;
    n = 0;
    while (!o_frame_done && n < 40) begin @(negedge clk); n++; end
    checks++; if (!o_frame_done) begin errors++; $display("FAIL lw_boundary got 0 want 1"); end
    push_frame(16'h2222, 4'h0);
    n = 0;
    while ((sb.size() != 0 || in_run) && n < 120) begin @(negedge clk); n++; end
    checks++; if (sb.size() != 0 || in_run) begin errors++; $display("FAIL lw_drain got %0d want 0", sb.size()); end
  endtask

  task automatic test_boundary_strobe();
    int n;
    n = 0;
    while (o_digit !== 4'b0111 && n < 60) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    upd = 1'b1; bcd = 16'h9031; dp = 4'b0010;
    @(negedge clk);
    upd = 1'b0;
    checks++; if (o_frame_done !== 1'b1) begin errors++; $display("FAIL bnd_align got %b want 1", o_frame_done); end
    push_frame(16'h9031, 4'b0010);
    @(negedge clk);
    checks++; if (o_pending !== 1'b0) begin errors++; $display("FAIL bnd_pending got %b want 0", o_pending); end
    n = 0;
    while ((sb.size() != 0 || in_run) && n < 120) begin @(negedge clk); n++; end
    checks++; if (sb.size() != 0 || in_run) begin errors++; $display("FAIL bnd_drain got %0d want 0", sb.size()); end
  endtask

  task automatic test_en_drop();
    int n;
    int on_cnt;
    n = 0;
    while (o_digit !== 4'b1011 && n < 60) begin @(negedge clk); n++; end
    en = 1'b0;
    @(negedge clk);
    checks++; if (o_digit !== 4'b1011) begin errors++; $display("FAIL drop_edge1 got %b want 1011", o_digit); end
    @(negedge clk);
    checks++; if (o_digit !== 4'hF) begin errors++; $display("FAIL drop_edge2 got %b want 1111", o_digit); end
    checks++; if (o_seg !== 8'hFF) begin errors++; $display("FAIL drop_seg got %h want ff", o_seg); end
    checks++; if (o_digit_sel !== 2'd0) begin errors++; $display("FAIL drop_sel got %0d want 0", o_digit_sel); end
    on_cnt = 0;
    repeat (5) begin @(negedge clk); if (o_digit !== 4'hF) on_cnt++; end
    checks++; if (on_cnt != 0) begin errors++; $display("FAIL idle_off got %0d want 0", on_cnt); end
    push_frame(16'h9031, 4'b0010);
    en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (o_digit === 4'hF && n < 20);
    checks++; if (n != 4) begin errors++; $display("FAIL restart_latency got %0d want 4", n); end
    checks++; if (o_digit_sel !== 2'd0) begin errors++; $display("FAIL restart_sel got %0d want 0", o_digit_sel); end
    n = 0;
    while ((sb.size() != 0 || in_run) && n < 120) begin @(negedge clk); n++; end
    checks++; if (sb.size() != 0 || in_run) begin errors++; $display("FAIL restart_drain got %0d want 0", sb.size()); end
  endtask

  task automatic test_dash_lzb();
    int n;
    int on_cnt;
    n = 0;
    while (o_digit !== 4'b1101 && n < 60) begin @(negedge clk); n++; end
    upd = 1'b1; bcd = 16'h00A5; dp = 4'h0;
    @(negedge clk);
    upd = 1'b0;
    n = 0;
    while (!o_frame_done && n < 40) begin @(negedge clk); n++; end
`ifdef FND_LEADING_ZERO_BLANK_EN
    push_slot(0, 4'h5, 1'b0);
    push_slot(1, 4'hA, 1'b0);
`else
    push_frame(16'h00A5, 4'h0);
`endif
    n = 0;
    while ((sb.size() != 0 || in_run) && n < 120) begin @(negedge clk); n++; end
    checks++; if (sb.size() != 0 || in_run) begin errors++; $display("FAIL dash_drain got %0d want 0", sb.size()); end
`ifdef FND_LEADING_ZERO_BLANK_EN
    n = 0;
    on_cnt = 0;
    while (!o_frame_done && n < 40) begin
      @(negedge clk);
      n++;
      if (o_digit !== 4'hF) on_cnt++;
    end
    checks++; if (on_cnt != 0 || !o_frame_done) begin errors++; $display("FAIL lzb_blank got %0d lit want 0", on_cnt); end
`endif
  endtask

  task automatic test_reset_midframe();
    int n;
    n = 0;
    while (o_digit !== 4'b1101 && n < 60) begin @(negedge clk); n++; end
    upd = 1'b1; bcd = 16'h4321; dp = 4'hF;
    @(negedge clk);
    upd = 1'b0;
    @(negedge clk);
    checks++; if (o_pending !== 1'b1) begin errors++; $display("FAIL rm_pend got %b want 1", o_pending); end
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    checks++; if (o_digit !== 4'hF) begin errors++; $display("FAIL rm_digit got %b want 1111", o_digit); end
    checks++; if (o_seg !== 8'hFF) begin errors++; $display("FAIL rm_seg got %h want ff", o_seg); end
    checks++; if (o_digit_sel !== 2'd0) begin errors++; $display("FAIL rm_sel got %0d want 0", o_digit_sel); end
    checks++; if (o_pending !== 1'b0) begin errors++; $display("FAIL rm_pending got %b want 0", o_pending); end
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL rm_frame_done got %b want 0", o_frame_done); end
    rst = 1'b0;
    @(negedge clk);
`ifdef FND_LEADING_ZERO_BLANK_EN
    push_slot(0, 4'h0, 1'b0);
`else
    push_frame(16'h0000, 4'h0);
`endif
    en = 1'b1;
    n = 0;
    while ((sb.size() != 0 || in_run) && n < 120) begin @(negedge clk); n++; end
    checks++; if (sb.size() != 0 || in_run) begin errors++; $display("FAIL rm_drain got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_pending();
    test_last_write();
    test_boundary_strobe();
    test_en_drop();
    test_dash_lzb();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
